// File: rtl/axi_sram_burst_master.sv
// axi_sram_burst_master: one-at-a-time AXI4 INCR burst initiator fed by a command/stream interface
module axi_sram_burst_master #(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_USER_WIDTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          cmd_valid_i,
    output logic                          cmd_ready_o,
    input  logic                          cmd_write_i,
    input  logic [AXI_ADDR_WIDTH-1:0]     cmd_addr_i,
    input  logic [7:0]                    cmd_len_i,
    input  logic [AXI_ID_WIDTH-1:0]       cmd_id_i,
    input  logic                          wdata_valid_i,
    output logic                          wdata_ready_o,
    input  logic [AXI_DATA_WIDTH-1:0]     wdata_i,
    input  logic [AXI_DATA_WIDTH/8-1:0]   wstrb_i,
    output logic                          rdata_valid_o,
    input  logic                          rdata_ready_i,
    output logic [AXI_DATA_WIDTH-1:0]     rdata_o,
    output logic                          rdata_last_o,
    output logic                          done_o,
    output logic [1:0]                    done_resp_o,
    output logic [1:0]                    done_err_o,
    output logic [AXI_ID_WIDTH-1:0]       axi_aw_id,
    output logic [AXI_ADDR_WIDTH-1:0]     axi_aw_addr,
    output logic [7:0]                    axi_aw_len,
    output logic [2:0]                    axi_aw_size,
    output logic [1:0]                    axi_aw_burst,
    output logic                          axi_aw_lock,
    output logic [3:0]                    axi_aw_cache,
    output logic [2:0]                    axi_aw_prot,
    output logic [3:0]                    axi_aw_qos,
    output logic [3:0]                    axi_aw_region,
    output logic [5:0]                    axi_aw_atop,
    output logic [AXI_USER_WIDTH-1:0]     axi_aw_user,
    output logic                          axi_aw_valid,
    input  logic                          axi_aw_ready,
    output logic [AXI_DATA_WIDTH-1:0]     axi_w_data,
    output logic [AXI_DATA_WIDTH/8-1:0]   axi_w_strb,
    output logic                          axi_w_last,
    output logic [AXI_USER_WIDTH-1:0]     axi_w_user,
    output logic                          axi_w_valid,
    input  logic                          axi_w_ready,
    input  logic [AXI_ID_WIDTH-1:0]       axi_b_id,
    input  logic [1:0]                    axi_b_resp,
    input  logic [AXI_USER_WIDTH-1:0]     axi_b_user,
    input  logic                          axi_b_valid,
    output logic                          axi_b_ready,
    output logic [AXI_ID_WIDTH-1:0]       axi_ar_id,
    output logic [AXI_ADDR_WIDTH-1:0]     axi_ar_addr,
    output logic [7:0]                    axi_ar_len,
    output logic [2:0]                    axi_ar_size,
    output logic [1:0]                    axi_ar_burst,
    output logic                          axi_ar_lock,
    output logic [3:0]                    axi_ar_cache,
    output logic [2:0]                    axi_ar_prot,
    output logic [3:0]                    axi_ar_qos,
    output logic [3:0]                    axi_ar_region,
    output logic [AXI_USER_WIDTH-1:0]     axi_ar_user,
    output logic                          axi_ar_valid,
    input  logic                          axi_ar_ready,
    input  logic [AXI_ID_WIDTH-1:0]       axi_r_id,
    input  logic [AXI_DATA_WIDTH-1:0]     axi_r_data,
    input  logic [1:0]                    axi_r_resp,
    input  logic                          axi_r_last,
    input  logic [AXI_USER_WIDTH-1:0]     axi_r_user,
    input  logic                          axi_r_valid,
    output logic                          axi_r_ready
);
    localparam int OFF = $clog2(AXI_DATA_WIDTH / 8);
    localparam logic [2:0] S_IDLE = 3'd0, S_AR = 3'd1, S_R = 3'd2, S_AW = 3'd3, S_W = 3'd4, S_B = 3'd5, S_DONE = 3'd6;
    logic [2:0]                state_q;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, cmd_addr_aligned;
    logic [7:0]                len_q;
    logic [AXI_ID_WIDTH-1:0]   id_q;
    logic [8:0]                cnt_q;
    logic [1:0]                resp_q, err_q;
    logic [31:0]               span;
    logic                      last, r_hs, w_hs, over_4k, unused;
    assign cmd_addr_aligned = cmd_addr_i & ~AXI_ADDR_WIDTH'(AXI_DATA_WIDTH / 8 - 1);
    assign span             = 32'(cmd_addr_aligned[11:0]) + ((32'(cmd_len_i) + 32'd1) << OFF);
    assign over_4k          = span > 32'd4096;
    assign last             = cnt_q == {1'b0, len_q};
    assign r_hs             = axi_r_valid && axi_r_ready;
    assign w_hs             = axi_w_valid && axi_w_ready;
    assign unused           = ^{axi_b_id, axi_b_user, axi_r_user};
    assign cmd_ready_o      = state_q == S_IDLE;
    assign done_o           = state_q == S_DONE;
    assign done_resp_o      = resp_q;
    assign done_err_o       = err_q;
    assign axi_ar_valid     = state_q == S_AR;
    assign axi_aw_valid     = state_q == S_AW;
    assign axi_b_ready      = state_q == S_B;
    assign axi_r_ready      = (state_q == S_R) && rdata_ready_i;
    assign rdata_valid_o    = (state_q == S_R) && axi_r_valid;
    assign rdata_o          = axi_r_data;
    assign rdata_last_o     = (state_q == S_R) && last;
    assign axi_w_valid      = (state_q == S_W) && wdata_valid_i;
    assign wdata_ready_o    = (state_q == S_W) && axi_w_ready;
    assign axi_w_data       = wdata_i;
    assign axi_w_strb       = wstrb_i;
    assign axi_w_last       = (state_q == S_W) && last;
    assign axi_w_user       = '0;
    assign axi_aw_id        = id_q;
    assign axi_aw_addr      = addr_q;
    assign axi_aw_len       = len_q;
    assign axi_aw_size      = 3'(OFF);
    assign axi_aw_burst     = 2'b01;
    assign axi_aw_lock      = 1'b0;
    assign axi_aw_cache     = '0;
    assign axi_aw_prot      = '0;
    assign axi_aw_qos       = '0;
    assign axi_aw_region    = '0;
    assign axi_aw_atop      = '0;
    assign axi_aw_user      = '0;
    assign axi_ar_id        = id_q;
    assign axi_ar_addr      = addr_q;
    assign axi_ar_len       = len_q;
    assign axi_ar_size      = 3'(OFF);
    assign axi_ar_burst     = 2'b01;
    assign axi_ar_lock      = 1'b0;
    assign axi_ar_cache     = '0;
    assign axi_ar_prot      = '0;
    assign axi_ar_qos       = '0;
    assign axi_ar_region    = '0;
    assign axi_ar_user      = '0;
    // Burst sequencing, beat counting and response/error merging
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            resp_q  <= '0;
            err_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (cmd_valid_i) begin
                    addr_q  <= cmd_addr_aligned;
                    len_q   <= cmd_len_i;
                    id_q    <= cmd_id_i;
                    cnt_q   <= '0;
                    resp_q  <= over_4k ? 2'b10 : 2'b00;
                    err_q   <= {1'b0, over_4k};
                    state_q <= over_4k ? S_DONE : (cmd_write_i ? S_AW : S_AR);
                end
                S_AR: if (axi_ar_ready) state_q <= S_R;
                S_AW: if (axi_aw_ready) state_q <= S_W;
                S_R: if (r_hs) begin
                    cnt_q    <= cnt_q + 9'd1;
                    resp_q   <= (axi_r_resp > resp_q) ? axi_r_resp : resp_q;
                    err_q[1] <= err_q[1] | (axi_r_last != last) | (axi_r_id != id_q);
                    if (last) state_q <= S_DONE;
                end
                S_W: if (w_hs) begin
                    cnt_q <= cnt_q + 9'd1;
                    if (last) state_q <= S_B;
                end
                S_B: if (axi_b_valid) begin
                    resp_q  <= axi_b_resp;
                    state_q <= S_DONE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
